// File: rtl/mem_access_sequencer_pkg.sv
// Shared reference-CPU definitions for the data-memory access sequencer.
package mem_access_sequencer_pkg;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_X = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } mem_state_t;

  typedef logic [3:0] strobe_t;

endpackage

// File: rtl/mem_access_sequencer_store_align.sv
// Combinational store alignment: byte strobe, lane-replicated write data, misalignment flag.
module store_align
  import mem_access_sequencer_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output strobe_t     strobe_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    strobe_o     = '0;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    unique case (mem_size_t'(size_i))
      MSIZE_B: begin
        strobe_o = strobe_t'(4'b0001 << addr_lo_i);
        wdata_o  = {4{wdata_i[7:0]}};
      end
      MSIZE_H: begin
        strobe_o     = strobe_t'(4'b0011 << {addr_lo_i[1], 1'b0});
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      MSIZE_W: begin
        strobe_o     = 4'hF;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      MSIZE_X: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// One data-bus access per load/store with alignment checking.
// Optional bus timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dbus_valid,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_strobe,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata
);

  mem_state_t  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [31:0] addr_q, addr_d;
  strobe_t     strobe_q, strobe_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;
  logic        busy_q, done_q, valid_q;

  strobe_t     sa_strobe;
  logic [31:0] sa_wdata;
  logic        sa_mis;
  logic        in_bus, complete, abort;

  store_align u_store_align (
    .size_i       (size),
    .addr_lo_i    (addr[1:0]),
    .wdata_i      (wdata),
    .strobe_o     (sa_strobe),
    .wdata_o      (sa_wdata),
    .misaligned_o (sa_mis)
  );

  assign in_bus   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign complete = ((state_q == ST_REQ) && dbus_addr_ok && dbus_data_ok) ||
                    ((state_q == ST_WAIT) && dbus_data_ok);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  // Counter holds cycles already spent in REQ/WAIT; abort on the last allowed one.
  assign abort = in_bus && !complete && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = in_bus ? cnt_q + 1'b1 : '0;
    bus_err_d = bus_err_q;
    if ((state_q == ST_IDLE) && start) bus_err_d = 1'b0;
    else if (abort)                    bus_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign abort          = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          addr_d     = {addr[31:2], 2'b00};
          strobe_d   = is_store ? sa_strobe : '0;
          wdata_d    = sa_wdata;
          addr_err_d = sa_mis;
          state_d    = sa_mis ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (complete)          state_d = ST_DONE;
        else if (abort)        state_d = ST_DONE;
        else if (dbus_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (complete || abort) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    if (complete && !is_store_q) rdata_d = dbus_rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      valid_q    <= (state_d == ST_REQ);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign addr_err    = addr_err_q;
  assign dbus_valid  = valid_q;
  assign dbus_addr   = addr_q;
  assign dbus_strobe = strobe_q;
  assign dbus_wdata  = wdata_q;

endmodule
